// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack data-memory port, stalls upstream
// while an access is outstanding, and presents the writeback bundle to MEM/WB.
module mem_access_stage #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        RegWrite_in,
    input  logic [1:0]  MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  MemSize_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] wdata_in,
    input  logic [31:0] wa_in,
    input  logic [31:0] instr_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        RegWrite_out,
    output logic [1:0]  MemtoReg_out,
    output logic [31:0] rd_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] wa_out,
    output logic [31:0] instr_out,
    output logic        stall_out,
    output logic [1:0]  exc_out
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] TO_LAST = 4'(ACK_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        req_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [2:0]  size_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic [31:0] wa_reg;
    logic [31:0] instr_reg;
    logic        regwrite_reg;
    logic [1:0]  memtoreg_reg;

    logic        is_mem;
    logic        misaligned;
    logic        latch;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  rbyte [4];
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    logic        regwrite_c;
    logic [1:0]  memtoreg_c;
    logic [31:0] rd_c, alu_c, wa_c, instr_c;
    logic        stall_c;
    logic [1:0]  exc_c;

    assign is_mem     = MemRead_in | MemWrite_in;
    assign misaligned = ((MemSize_in[1:0] == 2'b01) && alu_result_in[0]) ||
                        (MemSize_in[1] && (alu_result_in[1:0] != 2'b00));
    assign latch      = (state_reg == S_IDLE) && valid_in && is_mem && !misaligned;

    // Store lane steering; loads read the whole word and pick the lane on return.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = 32'd0;
        if (MemWrite_in) begin
            case (MemSize_in[1:0])
                2'b00: begin
                    be_calc    = 4'b0001 << alu_result_in[1:0];
                    wdata_calc = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    be_calc    = 4'b0011 << {alu_result_in[1], 1'b0};
                    wdata_calc = {2{wdata_in[15:0]}};
                end
                default: begin
                    be_calc    = 4'b1111;
                    wdata_calc = wdata_in;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = dm_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        lane_byte = rbyte[addr_reg[1:0]];
        lane_half = addr_reg[1] ? {rbyte[3], rbyte[2]} : {rbyte[1], rbyte[0]};
        case (size_reg[1:0])
            2'b00:   load_ext = {{24{~size_reg[2] & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{16{~size_reg[2] & lane_half[15]}}, lane_half};
            default: load_ext = dm_rdata;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        regwrite_c = 1'b0;
        memtoreg_c = 2'b00;
        rd_c       = 32'd0;
        alu_c      = 32'd0;
        wa_c       = 32'd0;
        instr_c    = 32'd0;
        stall_c    = 1'b0;
        exc_c      = 2'b00;
        case (state_reg)
            S_IDLE: begin
                if (valid_in && is_mem) begin
                    if (misaligned) begin
                        exc_c[0] = 1'b1;
                    end else begin
                        stall_c    = 1'b1;
                        state_next = S_WAIT;
                        cnt_next   = 4'd0;
                    end
                end else if (valid_in) begin
                    regwrite_c = RegWrite_in;
                    memtoreg_c = MemtoReg_in;
                    alu_c      = alu_result_in;
                    wa_c       = wa_in;
                    instr_c    = instr_in;
                end
            end
            S_WAIT: begin
                if (dm_ack) begin
                    regwrite_c = regwrite_reg;
                    memtoreg_c = memtoreg_reg;
                    rd_c       = we_reg ? 32'd0 : load_ext;
                    alu_c      = addr_reg;
                    wa_c       = wa_reg;
                    instr_c    = instr_reg;
                    state_next = S_IDLE;
                end else if (cnt_reg == TO_LAST) begin
                    // Abort: release the pipeline and flag the bus error instead.
                    exc_c[1]   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    stall_c  = 1'b1;
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 4'd0;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= 32'd0;
            size_reg     <= 3'd0;
            be_reg       <= 4'd0;
            wdata_reg    <= 32'd0;
            wa_reg       <= 32'd0;
            instr_reg    <= 32'd0;
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            req_reg   <= (state_next == S_WAIT);
            if (latch) begin
                we_reg       <= MemWrite_in;
                addr_reg     <= alu_result_in;
                size_reg     <= MemSize_in;
                be_reg       <= be_calc;
                wdata_reg    <= wdata_calc;
                wa_reg       <= wa_in;
                instr_reg    <= instr_in;
                regwrite_reg <= RegWrite_in;
                memtoreg_reg <= MemtoReg_in;
            end
        end
    end

    // Everything reads as zero while reset is held, including the registered request.
    assign dm_req         = req_reg & ~rst;
    assign dm_we          = we_reg & ~rst;
    assign dm_addr        = rst ? 32'd0 : {addr_reg[31:2], 2'b00};
    assign dm_be          = rst ? 4'd0 : be_reg;
    assign dm_wdata       = rst ? 32'd0 : wdata_reg;
    assign RegWrite_out   = regwrite_c & ~rst;
    assign MemtoReg_out   = rst ? 2'b00 : memtoreg_c;
    assign rd_out         = rst ? 32'd0 : rd_c;
    assign alu_result_out = rst ? 32'd0 : alu_c;
    assign wa_out         = rst ? 32'd0 : wa_c;
    assign instr_out      = rst ? 32'd0 : instr_c;
    assign stall_out      = stall_c & ~rst;
    assign exc_out        = rst ? 2'b00 : exc_c;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, RegWrite_in, MemRead_in, MemWrite_in;
    logic [1:0]  MemtoReg_in;
    logic [2:0]  MemSize_in;
    logic [31:0] alu_result_in, wdata_in, wa_in, instr_in;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        RegWrite_out, stall_out;
    logic [1:0]  MemtoReg_out, exc_out;
    logic [31:0] rd_out, alu_result_out, wa_out, instr_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .RegWrite_in(RegWrite_in),
        .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemSize_in(MemSize_in), .alu_result_in(alu_result_in), .wdata_in(wdata_in),
        .wa_in(wa_in), .instr_in(instr_in), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .rd_out(rd_out), .alu_result_out(alu_result_out), .wa_out(wa_out),
        .instr_out(instr_out), .stall_out(stall_out), .exc_out(exc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rw, input logic [1:0] mtr,
                          input logic mr, input logic mw, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] wa, input logic [31:0] ins);
        valid_in      = v;
        RegWrite_in   = rw;
        MemtoReg_in   = mtr;
        MemRead_in    = mr;
        MemWrite_in   = mw;
        MemSize_in    = sz;
        alu_result_in = addr;
        wdata_in      = wd;
        wa_in         = wa;
        instr_in      = ins;
    endtask

    // Issue the op already on the inputs; ack after 'waits' ack-less WAIT cycles.
    task automatic run_mem(input string tag, input int waits, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_rd,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic exp_we, input logic exp_rw, input logic [31:0] exp_wa,
                           input int exp_stalls);
        int stalls = 0;
        @(negedge clk);
        check({tag, "_idle_req"}, 32'(dm_req), 32'd0);
        check({tag, "_idle_rw"}, 32'(RegWrite_out), 32'd0);
        stalls += int'(stall_out);
        tick();
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check({tag, "_wait_req"}, 32'(dm_req), 32'd1);
            check({tag, "_wait_rw"}, 32'(RegWrite_out), 32'd0);
            check({tag, "_wait_stable_be"}, 32'(dm_be), 32'(exp_be));
            stalls += int'(stall_out);
            tick();
        end
        dm_ack   = 1'b1;
        dm_rdata = rdata;
        @(negedge clk);
        check({tag, "_req"}, 32'(dm_req), 32'd1);
        check({tag, "_addr"}, dm_addr, exp_addr);
        check({tag, "_be"}, 32'(dm_be), 32'(exp_be));
        check({tag, "_wdata"}, dm_wdata, exp_wd);
        check({tag, "_we"}, 32'(dm_we), 32'(exp_we));
        check({tag, "_rd"}, rd_out, exp_rd);
        check({tag, "_rw"}, 32'(RegWrite_out), 32'(exp_rw));
        check({tag, "_wa"}, wa_out, exp_wa);
        check({tag, "_ack_stall"}, 32'(stall_out), 32'd0);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        $display("txn %s addr=0x%08h rd=0x%08h be=%b stalls=%0d", tag, dm_addr, rd_out, dm_be, stalls);
        tick();
        dm_ack   = 1'b0;
        dm_rdata = 32'd0;
    endtask

    initial begin
        int req_cycles;
        rst      = 1'b1;
        dm_ack   = 1'b0;
        dm_rdata = 32'd0;
        set_op(1, 1, 2'b01, 0, 0, 3'b010, 32'h1234, 0, 5, 32'h0000_DEAD);
        @(negedge clk);
        check("rst_rw", 32'(RegWrite_out), 32'd0);
        check("rst_alu", alu_result_out, 32'd0);
        check("rst_req", 32'(dm_req), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        $display("txn reset");
        tick();
        rst = 1'b0;

        @(negedge clk);
        check("np_alu", alu_result_out, 32'h1234);
        check("np_wa", wa_out, 32'd5);
        check("np_rw", 32'(RegWrite_out), 32'd1);
        check("np_mtr", 32'(MemtoReg_out), 32'd1);
        check("np_instr", instr_out, 32'h0000_DEAD);
        check("np_rd", rd_out, 32'd0);
        check("np_stall", 32'(stall_out), 32'd0);
        check("np_req", 32'(dm_req), 32'd0);
        $display("txn nonmem alu=0x%08h wa=%0d", alu_result_out, wa_out);
        tick();

        set_op(1, 1, 2'b01, 1, 0, 3'b000, 32'h103, 0, 7, 32'h11);
        run_mem("lb", 0, 32'h80FF_0000, 32'h100, 32'hFFFF_FF80, 4'b1111, 0, 0, 1, 7, 1);
        set_op(1, 1, 2'b01, 1, 0, 3'b100, 32'h103, 0, 7, 32'h12);
        run_mem("lbu", 0, 32'h80FF_0000, 32'h100, 32'h0000_0080, 4'b1111, 0, 0, 1, 7, 1);
        set_op(1, 0, 2'b00, 0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 0, 32'h22);
        run_mem("sh", 3, 32'h1234_5678, 32'h100, 0, 4'b1100, 32'hABCD_ABCD, 1, 0, 0, 4);
        set_op(1, 1, 2'b01, 1, 0, 3'b001, 32'h102, 0, 9, 32'h33);
        run_mem("lh", 0, 32'h8001_1234, 32'h100, 32'hFFFF_8001, 4'b1111, 0, 0, 1, 9, 1);
        set_op(1, 0, 2'b00, 1, 1, 3'b000, 32'h101, 32'h1234_565A, 0, 32'h44);
        run_mem("sb", 1, 32'hFFFF_FFFF, 32'h100, 0, 4'b0010, 32'h5A5A_5A5A, 1, 0, 0, 2);
        set_op(1, 1, 2'b01, 1, 0, 3'b011, 32'h104, 0, 3, 32'h55);
        run_mem("lw", 0, 32'hCAFE_BABE, 32'h104, 32'hCAFE_BABE, 4'b1111, 0, 0, 1, 3, 1);

        set_op(1, 1, 2'b01, 1, 0, 3'b010, 32'h101, 0, 4, 32'h66);
        @(negedge clk);
        check("mis_exc", 32'(exc_out), 32'd1);
        check("mis_req", 32'(dm_req), 32'd0);
        check("mis_rw", 32'(RegWrite_out), 32'd0);
        check("mis_stall", 32'(stall_out), 32'd0);
        $display("txn misaligned exc=%b", exc_out);
        tick();
        set_op(0, 1, 2'b01, 0, 0, 3'b010, 32'h777, 0, 6, 32'h77);
        @(negedge clk);
        check("bub_rw", 32'(RegWrite_out), 32'd0);
        check("bub_alu", alu_result_out, 32'd0);
        check("bub_req", 32'(dm_req), 32'd0);
        check("bub_exc", 32'(exc_out), 32'd0);
        $display("txn bubble");
        tick();

        set_op(1, 1, 2'b01, 1, 0, 3'b010, 32'h200, 0, 8, 32'h88);
        @(negedge clk);
        check("to_idle_stall", 32'(stall_out), 32'd1);
        tick();
        req_cycles = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            req_cycles += int'(dm_req);
            if (i < 15) begin
                check("to_wait_exc", 32'(exc_out), 32'd0);
                check("to_wait_stall", 32'(stall_out), 32'd1);
            end else begin
                check("to_exc", 32'(exc_out), 32'd2);
                check("to_stall", 32'(stall_out), 32'd0);
                check("to_rw", 32'(RegWrite_out), 32'd0);
            end
            tick();
        end
        check("to_req_cycles", 32'(req_cycles), 32'd15);
        set_op(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        @(negedge clk);
        check("to_after_req", 32'(dm_req), 32'd0);
        check("to_after_exc", 32'(exc_out), 32'd0);
        $display("txn timeout req_cycles=%0d", req_cycles);
        tick();

        set_op(1, 1, 2'b01, 1, 0, 3'b010, 32'h300, 0, 2, 32'h99);
        @(negedge clk);
        check("rw_idle_stall", 32'(stall_out), 32'd1);
        tick();
        @(negedge clk);
        check("rw_wait_req", 32'(dm_req), 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rw_rst_req", 32'(dm_req), 32'd0);
        check("rw_rst_exc", 32'(exc_out), 32'd0);
        tick();
        rst = 1'b0;
        set_op(1, 1, 2'b10, 0, 0, 3'b010, 32'hBEEF, 0, 32'h1F, 32'hAA);
        @(negedge clk);
        check("rw_np_alu", alu_result_out, 32'hBEEF);
        check("rw_np_wa", wa_out, 32'h1F);
        check("rw_np_rw", 32'(RegWrite_out), 32'd1);
        check("rw_np_req", 32'(dm_req), 32'd0);
        check("rw_np_stall", 32'(stall_out), 32'd0);
        check("rw_np_exc", 32'(exc_out), 32'd0);
        $display("txn reset_in_wait then nonmem alu=0x%08h", alu_result_out);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage datapath between the EX/MEM pipeline register and the MEM/WB register. Runs loads and stores on a data memory with a req/ack handshake, stalling upstream until the access completes. Extracts and extends load data, generates store byte enables, and detects misaligned accesses and bus timeouts. Presents the writeback bundle (RegWrite, MemtoReg, read data, ALU result, write address, instruction) to MEM/WB each cycle.

Parameters:
ACK_TIMEOUT, 15, WAIT-state cycles without dm_ack before abort (>=1)

Ports:
clk  in  1  clock, posedge
rst  in  1  synchronous active-high reset
valid_in  in  1  EX/MEM holds a real instruction
RegWrite_in  in  1  WB control
MemtoReg_in  in  2  WB control, passed through
MemRead_in  in  1  load
MemWrite_in  in  1  store
MemSize_in  in  3  [1:0] 00 byte, 01 half, 10 word (11 treated as word); [2]=1 zero-extend load
alu_result_in  in  32  effective address / ALU result
wdata_in  in  32  store data (low-aligned)
wa_in  in  32  destination register address, passed through
instr_in  in  32  instruction, passed through
dm_req  out  1  memory request, registered
dm_we  out  1  1 store, 0 load
dm_addr  out  32  word address {addr[31:2],2'b00}
dm_be  out  4  byte enables, little-endian
dm_wdata  out  32  lane-replicated store data
dm_ack  in  1  access done; dm_rdata valid same cycle for loads
dm_rdata  in  32  read word
RegWrite_out  out  1  to MEM/WB
MemtoReg_out  out  2  to MEM/WB
rd_out  out  32  extended load data, to MEM/WB
alu_result_out  out  32  to MEM/WB
wa_out  out  32  to MEM/WB
instr_out  out  32  to MEM/WB
stall_out  out  1  hold PC/IF/ID/EX/MEM this cycle
exc_out  out  2  1-cycle pulse: bit0 misaligned, bit1 bus timeout

Behaviour:
- FSM IDLE/WAIT, 4-bit wait counter. Reset: IDLE, counter 0, dm_req 0, all request regs 0. While rst=1, all outputs 0.
- Bubble = RegWrite_out 0, MemtoReg_out/rd_out/alu_result_out/wa_out/instr_out 0.
- IDLE, non-memory op or valid_in=0: combinational pass-through, rd_out 0, stall_out 0, zero added latency. valid_in=0 gives a bubble.
- IDLE, valid_in & (MemRead|MemWrite), aligned: latch address, size, sign, wdata, wa, instr, RegWrite, MemtoReg. Drive bubble with stall_out 1. Next edge: WAIT, dm_req 1, counter 0. MemRead and MemWrite both set: store wins.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. In IDLE: no request, bubble, stall_out 0, exc_out[0] 1 for that cycle.
- WAIT: dm_req, dm_we, dm_addr, dm_be, dm_wdata held stable from latched regs. dm_ack is sampled only in WAIT.
- WAIT with dm_ack: outputs = latched fields, rd_out = extracted data (stores: rd_out 0), stall_out 0. Next edge: IDLE, dm_req 0. Minimum memory-op latency is 2 cycles, with 1 stall cycle.
- WAIT without dm_ack: bubble, stall_out 1, counter+1.
- Timeout: when counter = ACK_TIMEOUT-1 and still no dm_ack, abort. Drive bubble, stall_out 0, exc_out[1] 1 for one cycle; next edge IDLE, dm_req 0.
- Load extraction: byte lane addr[1:0], half lane addr[1]. Sign- or zero-extend to 32 bits per MemSize_in[2]. Word loads pass through.
- Store: byte is dm_be = 4'b0001<<addr[1:0], dm_wdata = {4{wdata[7:0]}}. Half is dm_be = 4'b0011<<(2*addr[1]), dm_wdata = {2{wdata[15:0]}}. Word is dm_be 4'b1111. Loads drive dm_be 4'b1111 and dm_wdata 0.
- rst asserted in WAIT: IDLE and dm_req 0 at the next edge; the pending access is dropped with no exc pulse.

Test Plan:
- Non-memory op: addr 0x1234, wa 5, RegWrite 1 -> same cycle alu_result_out 0x1234, wa_out 5, RegWrite_out 1, stall_out 0, dm_req stays 0.
- lb addr 0x103, dm_rdata 0x80FF_0000, ack in 1st WAIT cycle -> stall 1 cycle, dm_addr 0x100, rd_out 0xFFFF_FF80. Same access with lbu -> rd_out 0x80.
- sh addr 0x102, wdata 0xABCD, ack after 3 WAIT cycles -> dm_be 4'b1100, dm_wdata 0xABCD_ABCD, dm_we 1, stall_out high 4 cycles, bubble outputs until the ack cycle.
- lw addr 0x101 -> exc_out 2'b01 for one cycle, no dm_req, RegWrite_out 0, stall_out 0.
- lw with dm_ack never asserted, ACK_TIMEOUT 15 -> 15 WAIT cycles, exc_out 2'b10 on the 15th, stall_out 0 that cycle, dm_req low next.
- rst pulsed during WAIT -> dm_req 0 and IDLE next edge; a following non-memory op passes through correctly.
